present_state_ctrl: RTL and testbench
=====================================

PRESENT_STATE_CTRL -- requirements
Module: present_state_ctrl

Interface
REQ-001 The block SHALL use reset rst, synchronous, active-high, and clock clk.
REQ-002 Parameter BUF_BLKS, default 2: data buffer capacity in blocks (1..3).
REQ-003 Ports (name, direction, width, meaning) SHALL be:
clk  in  1  clock
rst  in  1  sync reset
cmd_issue  in  1  pulse: host wrote command register
cmd_with_data  in  1  issued command has data phase (sampled with cmd_issue)
cmd_dir_read  in  1  1=read, 0=write (sampled with cmd_issue)
cmd_busy_resp  in  1  R1b-type response (sampled with cmd_issue)
blk_cnt  in  16  block count (sampled with cmd_issue)
cmd_end  in  1  pulse: response received
cmd_error  in  1  pulse: CMD timeout/CRC error
dat_block_end  in  1  pulse: one block finished on DAT lines
dat_busy  in  1  DAT0 held low by card
host_blk_read  in  1  pulse: host drained one block from buffer
host_blk_written  in  1  pulse: host filled one block in buffer
abort  in  1  pulse: software reset for CMD/DAT
cmd_inhibit_cmd  out  1  present-state bit 0
cmd_inhibit_dat  out  1  present-state bit 1
dat_line_active  out  1  present-state bit 2
write_xfer_active  out  1  present-state bit 8
read_xfer_active  out  1  present-state bit 9
buf_wr_en  out  1  present-state bit 10
buf_rd_en  out  1  present-state bit 11
cmd_complete  out  1  one-cycle pulse
xfer_complete  out  1  one-cycle pulse
cmd_reject  out  1  one-cycle pulse: cmd_issue ignored
blocks_left  out  16  blocks not yet transferred on DAT
REQ-004 All outputs SHALL be registered.

Function
REQ-005 CMD FSM states C_IDLE, C_BUSY; DAT FSM states D_IDLE, D_READ, D_WRITE, D_BUSY.
REQ-006 cmd_issue SHALL be accepted only if cmd_inhibit_cmd=0 and, when cmd_with_data or cmd_busy_resp, cmd_inhibit_dat=0 and (not cmd_with_data or blk_cnt!=0); otherwise cmd_reject pulses next cycle, no state change.
REQ-007 Accept at cycle N: cmd_inhibit_cmd=1 at N+1; if data/busy: cmd_inhibit_dat=1, blocks_left=blk_cnt at N+1.
REQ-008 cmd_end in C_BUSY: C_IDLE, cmd_inhibit_cmd=0, cmd_complete pulse, next cycle; cmd_end in C_IDLE ignored.
REQ-009 cmd_error in C_BUSY: C_IDLE, cmd_inhibit_cmd=0, no cmd_complete; pending data phase cancelled (DAT FSM to D_IDLE, all DAT outputs 0, blocks_left=0, no xfer_complete).
REQ-010 Internal pend counter (0..BUF_BLKS) = blocks held in buffer.
REQ-011 D_READ (entered at acceptance): read_xfer_active=1; dat_line_active=1 while blocks_left>0 and pend<BUF_BLKS; dat_block_end decrements blocks_left, increments pend; host_blk_read decrements pend; buf_rd_en=(pend>0).
REQ-012 D_READ exit when blocks_left=0 and pend=0: D_IDLE, read_xfer_active=0, cmd_inhibit_dat=0, xfer_complete pulse.
REQ-013 D_WRITE: write_xfer_active=1; buf_wr_en=1 while host-written blocks < accepted count and pend<BUF_BLKS; host_blk_written increments pend; dat_line_active=(pend>0); dat_block_end decrements pend and blocks_left.
REQ-014 D_WRITE with blocks_left reaching 0: D_BUSY; write_xfer_active=0; dat_line_active=1 until dat_busy=0 observed, then D_IDLE, cmd_inhibit_dat=0, xfer_complete pulse.
REQ-015 R1b without data: enter D_BUSY after cmd_end; exit as REQ-014 without xfer_complete.
REQ-016 Simultaneous increment/decrement of pend in one cycle SHALL leave pend unchanged; pend SHALL saturate at 0 and BUF_BLKS; events exceeding bounds ignored.
REQ-017 dat_block_end/host pulses in D_IDLE SHALL be ignored.
REQ-018 abort SHALL return both FSMs to idle next cycle, all outputs 0, no completion pulses; abort overrides all same-cycle inputs.

Reset
REQ-019 rst SHALL force C_IDLE, D_IDLE, pend=0, every output 0, next clock edge, overriding all inputs including mid-transfer.

Verification
REQ-020 Non-data cmd: cmd_issue, cmd_end 5 cycles later -> inhibit_cmd 1 for 5 cycles, cmd_complete single pulse, inhibit_dat stays 0.
REQ-021 Read blk_cnt=3, BUF_BLKS=2, host never reads -> dat_line_active drops after 2 blocks; then 1 host_blk_read -> third block completes; xfer_complete after pend=0.
REQ-022 Write blk_cnt=2 -> buf_wr_en 1, two host_blk_written, two dat_block_end, dat_busy 4 cycles -> xfer_complete 1 cycle after dat_busy falls.
REQ-023 cmd_issue with data while inhibit_dat=1, and with blk_cnt=0 -> cmd_reject pulses, state unchanged.
REQ-024 Same-cycle dat_block_end and host_blk_read at pend=1 -> pend stays 1, blocks_left decrements.
REQ-025 abort and rst mid-read (blocks_left=5) -> all outputs 0 next cycle, no xfer_complete; new command accepted afterwards.

Source files
------------

// File: rtl/present_state_ctrl_if.sv
// Host-side command/data event bus and present-state outputs of present_state_ctrl.
// master drives the events and reads status; slave is the controller.
interface present_state_ctrl_if;
  logic        cmd_issue;
  logic        cmd_with_data;
  logic        cmd_dir_read;
  logic        cmd_busy_resp;
  logic [15:0] blk_cnt;
  logic        cmd_end;
  logic        cmd_error;
  logic        dat_block_end;
  logic        dat_busy;
  logic        host_blk_read;
  logic        host_blk_written;
  logic        abort;

  logic        cmd_inhibit_cmd;
  logic        cmd_inhibit_dat;
  logic        dat_line_active;
  logic        write_xfer_active;
  logic        read_xfer_active;
  logic        buf_wr_en;
  logic        buf_rd_en;
  logic        cmd_complete;
  logic        xfer_complete;
  logic        cmd_reject;
  logic [15:0] blocks_left;

  modport master (
    output cmd_issue, cmd_with_data, cmd_dir_read, cmd_busy_resp, blk_cnt, cmd_end, cmd_error,
           dat_block_end, dat_busy, host_blk_read, host_blk_written, abort,
    input  cmd_inhibit_cmd, cmd_inhibit_dat, dat_line_active, write_xfer_active,
           read_xfer_active, buf_wr_en, buf_rd_en, cmd_complete, xfer_complete, cmd_reject,
           blocks_left
  );

  modport slave (
    input  cmd_issue, cmd_with_data, cmd_dir_read, cmd_busy_resp, blk_cnt, cmd_end, cmd_error,
           dat_block_end, dat_busy, host_blk_read, host_blk_written, abort,
    output cmd_inhibit_cmd, cmd_inhibit_dat, dat_line_active, write_xfer_active,
           read_xfer_active, buf_wr_en, buf_rd_en, cmd_complete, xfer_complete, cmd_reject,
           blocks_left
  );
endinterface

// File: rtl/present_state_ctrl.sv
// SD host present-state controller: CMD and DAT FSMs with buffer occupancy tracking.
// Every output is a register loaded from the next-state values.
module present_state_ctrl #(
  parameter int unsigned BUF_BLKS = 2
) (
  input logic                 clk,
  input logic                 rst,
  present_state_ctrl_if.slave bus
);

  localparam logic [1:0] BufMax = 2'(BUF_BLKS);

  typedef enum logic {C_IDLE, C_BUSY} cState_e;
  typedef enum logic [1:0] {D_IDLE, D_READ, D_WRITE, D_BUSY} dState_e;

  cState_e     cStateQ, cStateD;
  dState_e     dStateQ, dStateD;
  logic [1:0]  pendQ, pendD;
  logic [15:0] blocksLeftQ, blocksLeftD;
  logic [15:0] totalQ, totalD;
  logic [15:0] wrCntQ, wrCntD;
  logic        cmdDatQ, cmdDatD;     // current command owns a data/busy phase
  logic        r1bPendQ, r1bPendD;   // busy-only response waiting for cmd_end
  logic        xferBusyQ, xferBusyD; // D_BUSY follows a write, so completion pulses

  logic inhCmdQ, inhDatQ, datLineQ, wrActQ, rdActQ, bufWrQ, bufRdQ;
  logic cmdCompleteQ, xferCompleteQ, cmdRejectQ;
  logic inhCmdD, inhDatD, datLineD, wrActD, rdActD, bufWrD, bufRdD;
  logic cmdCompleteD, xferCompleteD, cmdRejectD;

  logic pendInc, pendDec, needDat, inhDatNow;

  always_comb begin
    cStateD       = cStateQ;
    dStateD       = dStateQ;
    pendD         = pendQ;
    blocksLeftD   = blocksLeftQ;
    totalD        = totalQ;
    wrCntD        = wrCntQ;
    cmdDatD       = cmdDatQ;
    r1bPendD      = r1bPendQ;
    xferBusyD     = xferBusyQ;
    cmdCompleteD  = 1'b0;
    xferCompleteD = 1'b0;
    cmdRejectD    = 1'b0;
    pendInc       = 1'b0;
    pendDec       = 1'b0;
    needDat       = bus.cmd_with_data | bus.cmd_busy_resp;
    inhDatNow     = (dStateQ != D_IDLE) | r1bPendQ;

    // Data phase progress; increments/decrements beyond the buffer bounds are dropped.
    unique case (dStateQ)
      D_READ: begin
        pendInc = bus.dat_block_end && (blocksLeftQ != 16'd0) && (pendQ < BufMax);
        pendDec = bus.host_blk_read && (pendQ != 2'd0);
        if (pendInc) blocksLeftD = blocksLeftQ - 16'd1;
      end
      D_WRITE: begin
        pendInc = bus.host_blk_written && (wrCntQ < totalQ) && (pendQ < BufMax);
        pendDec = bus.dat_block_end && (pendQ != 2'd0) && (blocksLeftQ != 16'd0);
        if (pendInc) wrCntD = wrCntQ + 16'd1;
        if (pendDec) blocksLeftD = blocksLeftQ - 16'd1;
      end
      D_BUSY: begin
        if (!bus.dat_busy) begin
          dStateD       = D_IDLE;
          xferCompleteD = xferBusyQ;
          xferBusyD     = 1'b0;
        end
      end
      default: ;
    endcase

    if (pendInc && !pendDec) pendD = pendQ + 2'd1;
    else if (pendDec && !pendInc) pendD = pendQ - 2'd1;

    if (dStateQ == D_READ && blocksLeftD == 16'd0 && pendD == 2'd0) begin
      dStateD       = D_IDLE;
      xferCompleteD = 1'b1;
    end
    if (dStateQ == D_WRITE && blocksLeftD == 16'd0) begin
      dStateD   = D_BUSY;
      xferBusyD = 1'b1;
    end

    unique case (cStateQ)
      C_IDLE: begin
        if (bus.cmd_issue) begin
          if (!needDat || (!inhDatNow && (!bus.cmd_with_data || bus.blk_cnt != 16'd0))) begin
            cStateD = C_BUSY;
            cmdDatD = needDat;
            if (needDat) begin
              pendD     = 2'd0;
              wrCntD    = 16'd0;
              xferBusyD = 1'b0;
              // A busy-only response carries no block count.
              if (bus.cmd_with_data) begin
                blocksLeftD = bus.blk_cnt;
                totalD      = bus.blk_cnt;
                dStateD     = bus.cmd_dir_read ? D_READ : D_WRITE;
              end else begin
                r1bPendD = 1'b1;
              end
            end
          end else begin
            cmdRejectD = 1'b1;
          end
        end
      end
      C_BUSY: begin
        cmdRejectD = bus.cmd_issue;
        if (bus.cmd_error) begin
          cStateD = C_IDLE;
          cmdDatD = 1'b0;
          if (cmdDatQ) begin
            dStateD       = D_IDLE;
            pendD         = 2'd0;
            blocksLeftD   = 16'd0;
            wrCntD        = 16'd0;
            totalD        = 16'd0;
            r1bPendD      = 1'b0;
            xferBusyD     = 1'b0;
            xferCompleteD = 1'b0;
          end
        end else if (bus.cmd_end) begin
          cStateD      = C_IDLE;
          cmdDatD      = 1'b0;
          cmdCompleteD = 1'b1;
          if (r1bPendQ) begin
            r1bPendD  = 1'b0;
            dStateD   = D_BUSY;
            xferBusyD = 1'b0;
          end
        end
      end
      default: ;
    endcase

    if (bus.abort) begin
      cStateD       = C_IDLE;
      dStateD       = D_IDLE;
      pendD         = 2'd0;
      blocksLeftD   = 16'd0;
      totalD        = 16'd0;
      wrCntD        = 16'd0;
      cmdDatD       = 1'b0;
      r1bPendD      = 1'b0;
      xferBusyD     = 1'b0;
      cmdCompleteD  = 1'b0;
      xferCompleteD = 1'b0;
      cmdRejectD    = 1'b0;
    end
  end

  always_comb begin
    datLineD = 1'b0;
    unique case (dStateD)
      D_READ:  datLineD = (blocksLeftD != 16'd0) && (pendD < BufMax);
      D_WRITE: datLineD = (pendD != 2'd0);
      D_BUSY:  datLineD = 1'b1;
      default: datLineD = 1'b0;
    endcase
  end

  assign inhCmdD = (cStateD == C_BUSY);
  assign inhDatD = (dStateD != D_IDLE) | r1bPendD;
  assign wrActD  = (dStateD == D_WRITE);
  assign rdActD  = (dStateD == D_READ);
  assign bufWrD  = (dStateD == D_WRITE) && (wrCntD < totalD) && (pendD < BufMax);
  assign bufRdD  = (dStateD == D_READ) && (pendD != 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      cStateQ       <= C_IDLE;
      dStateQ       <= D_IDLE;
      pendQ         <= 2'd0;
      blocksLeftQ   <= 16'd0;
      totalQ        <= 16'd0;
      wrCntQ        <= 16'd0;
      cmdDatQ       <= 1'b0;
      r1bPendQ      <= 1'b0;
      xferBusyQ     <= 1'b0;
      inhCmdQ       <= 1'b0;
      inhDatQ       <= 1'b0;
      datLineQ      <= 1'b0;
      wrActQ        <= 1'b0;
      rdActQ        <= 1'b0;
      bufWrQ        <= 1'b0;
      bufRdQ        <= 1'b0;
      cmdCompleteQ  <= 1'b0;
      xferCompleteQ <= 1'b0;
      cmdRejectQ    <= 1'b0;
    end else begin
      cStateQ       <= cStateD;
      dStateQ       <= dStateD;
      pendQ         <= pendD;
      blocksLeftQ   <= blocksLeftD;
      totalQ        <= totalD;
      wrCntQ        <= wrCntD;
      cmdDatQ       <= cmdDatD;
      r1bPendQ      <= r1bPendD;
      xferBusyQ     <= xferBusyD;
      inhCmdQ       <= inhCmdD;
      inhDatQ       <= inhDatD;
      datLineQ      <= datLineD;
      wrActQ        <= wrActD;
      rdActQ        <= rdActD;
      bufWrQ        <= bufWrD;
      bufRdQ        <= bufRdD;
      cmdCompleteQ  <= cmdCompleteD;
      xferCompleteQ <= xferCompleteD;
      cmdRejectQ    <= cmdRejectD;
    end
  end

  assign bus.cmd_inhibit_cmd   = inhCmdQ;
  assign bus.cmd_inhibit_dat   = inhDatQ;
  assign bus.dat_line_active   = datLineQ;
  assign bus.write_xfer_active = wrActQ;
  assign bus.read_xfer_active  = rdActQ;
  assign bus.buf_wr_en         = bufWrQ;
  assign bus.buf_rd_en         = bufRdQ;
  assign bus.cmd_complete      = cmdCompleteQ;
  assign bus.xfer_complete     = xferCompleteQ;
  assign bus.cmd_reject        = cmdRejectQ;
  assign bus.blocks_left       = blocksLeftQ;

endmodule

// File: tb/tb_present_state_ctrl.sv
// Bench for present_state_ctrl: event-level model checked every cycle plus directed
// scenarios with hand-computed expectations.
module tb_present_state_ctrl;
  localparam int BufBlks = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  present_state_ctrl_if bus ();

  present_state_ctrl #(.BUF_BLKS(BufBlks)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int nCompared   = 0;
  int nMismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: transfer mode plus plain counts of blocks on the card side and in the buffer.
  typedef enum {MIdle, MRead, MWrite, MBusy} mode_e;
  mode_e mMode;
  int    mLeft, mPend, mWritten, mTotal;
  bit    mCmdBusy, mCmdDat, mR1b, mBusyXfer, modelValid = 1'b0;
  bit    eCC, eXC, eRej;

  task automatic modelStep();
    int  inc, dec;
    bit  wasBusy, datFree, need;
    inc = 0; dec = 0;
    eCC = 1'b0; eXC = 1'b0; eRej = 1'b0;
    if (rst || bus.abort) begin
      mMode = MIdle; mLeft = 0; mPend = 0; mWritten = 0; mTotal = 0;
      mCmdBusy = 1'b0; mCmdDat = 1'b0; mR1b = 1'b0; mBusyXfer = 1'b0;
      return;
    end
    wasBusy = mCmdBusy;
    datFree = (mMode == MIdle) && !mR1b;
    case (mMode)
      MRead: begin
        if (bus.dat_block_end && mLeft > 0 && mPend < BufBlks) begin mLeft--; inc = 1; end
        if (bus.host_blk_read && mPend > 0) dec = 1;
        mPend += inc - dec;
        if (mLeft == 0 && mPend == 0) begin mMode = MIdle; eXC = 1'b1; end
      end
      MWrite: begin
        if (bus.host_blk_written && mWritten < mTotal && mPend < BufBlks) begin
          mWritten++; inc = 1;
        end
        if (bus.dat_block_end && mPend > 0 && mLeft > 0) begin mLeft--; dec = 1; end
        mPend += inc - dec;
        if (mLeft == 0) begin mMode = MBusy; mBusyXfer = 1'b1; end
      end
      MBusy: if (!bus.dat_busy) begin mMode = MIdle; eXC = mBusyXfer; end
      default: ;
    endcase
    if (wasBusy) begin
      if (bus.cmd_error) begin
        mCmdBusy = 1'b0;
        if (mCmdDat) begin
          mMode = MIdle; mLeft = 0; mPend = 0; mR1b = 1'b0; eXC = 1'b0;
        end
        mCmdDat = 1'b0;
      end else if (bus.cmd_end) begin
        mCmdBusy = 1'b0; mCmdDat = 1'b0; eCC = 1'b1;
        if (mR1b) begin mR1b = 1'b0; mMode = MBusy; mBusyXfer = 1'b0; end
      end
    end
    if (bus.cmd_issue) begin
      need = bus.cmd_with_data || bus.cmd_busy_resp;
      if (!wasBusy && (!need || (datFree && (!bus.cmd_with_data || bus.blk_cnt != 0)))) begin
        mCmdBusy = 1'b1;
        mCmdDat  = need;
        if (bus.cmd_with_data) begin
          mLeft = int'(bus.blk_cnt); mTotal = mLeft; mWritten = 0; mPend = 0;
          mMode = bus.cmd_dir_read ? MRead : MWrite;
        end else if (need) begin
          mR1b = 1'b1;
        end
      end else begin
        eRej = 1'b1;
      end
    end
  endtask

  always @(posedge clk) begin
    modelStep();
    modelValid = 1'b1;
  end

  // Compare every output each cycle, away from the active edge.
  always @(negedge clk) begin
    if (modelValid) begin
      check("inhibit_cmd", 32'(bus.cmd_inhibit_cmd), 32'(mCmdBusy));
      check("inhibit_dat", 32'(bus.cmd_inhibit_dat), 32'((mMode != MIdle) || mR1b));
      check("dat_line_active", 32'(bus.dat_line_active),
            32'((mMode == MBusy) || (mMode == MWrite && mPend > 0) ||
                (mMode == MRead && mLeft > 0 && mPend < BufBlks)));
      check("write_xfer_active", 32'(bus.write_xfer_active), 32'(mMode == MWrite));
      check("read_xfer_active", 32'(bus.read_xfer_active), 32'(mMode == MRead));
      check("buf_wr_en", 32'(bus.buf_wr_en),
            32'(mMode == MWrite && mWritten < mTotal && mPend < BufBlks));
      check("buf_rd_en", 32'(bus.buf_rd_en), 32'(mMode == MRead && mPend > 0));
      check("cmd_complete", 32'(bus.cmd_complete), 32'(eCC));
      check("xfer_complete", 32'(bus.xfer_complete), 32'(eXC));
      check("cmd_reject", 32'(bus.cmd_reject), 32'(eRej));
      check("blocks_left", 32'(bus.blocks_left), 32'(mLeft));
    end
  end

  function automatic logic [31:0] allOut();
    return 32'({bus.cmd_inhibit_cmd, bus.cmd_inhibit_dat, bus.dat_line_active,
                bus.write_xfer_active, bus.read_xfer_active, bus.buf_wr_en, bus.buf_rd_en,
                bus.cmd_complete, bus.xfer_complete, bus.cmd_reject, bus.blocks_left});
  endfunction

  task automatic clearIn();
    bus.cmd_issue = 1'b0; bus.cmd_with_data = 1'b0; bus.cmd_dir_read = 1'b0;
    bus.cmd_busy_resp = 1'b0; bus.blk_cnt = 16'd0; bus.cmd_end = 1'b0; bus.cmd_error = 1'b0;
    bus.dat_block_end = 1'b0; bus.dat_busy = 1'b0; bus.host_blk_read = 1'b0;
    bus.host_blk_written = 1'b0; bus.abort = 1'b0;
  endtask

  // Issue for one cycle; returns at the negedge where the acceptance result is visible.
  task automatic issue(input bit withData, input bit rd, input bit busyResp, input int blk);
    bus.cmd_issue = 1'b1; bus.cmd_with_data = withData; bus.cmd_dir_read = rd;
    bus.cmd_busy_resp = busyResp; bus.blk_cnt = 16'(blk);
    @(negedge clk);
    bus.cmd_issue = 1'b0; bus.cmd_with_data = 1'b0; bus.cmd_dir_read = 1'b0;
    bus.cmd_busy_resp = 1'b0; bus.blk_cnt = 16'd0;
  endtask

  task automatic pulseEv(input bit be, input bit hr, input bit hw, input bit ce, input bit er,
                         input bit ab);
    bus.dat_block_end = be; bus.host_blk_read = hr; bus.host_blk_written = hw;
    bus.cmd_end = ce; bus.cmd_error = er; bus.abort = ab;
    @(negedge clk);
    bus.dat_block_end = 1'b0; bus.host_blk_read = 1'b0; bus.host_blk_written = 1'b0;
    bus.cmd_end = 1'b0; bus.cmd_error = 1'b0; bus.abort = 1'b0;
  endtask

  initial begin
    int inhCnt, ccCnt, datSeen;
    rst = 1'b1;
    clearIn();
    repeat (2) @(negedge clk);
    check("reset_all_zero", allOut(), 32'd0);
    rst = 1'b0;

    // Non-data command, response five cycles after issue.
    bus.cmd_issue = 1'b1;
    @(negedge clk);
    bus.cmd_issue = 1'b0;
    inhCnt = 0; ccCnt = 0; datSeen = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.cmd_inhibit_cmd) inhCnt++;
      if (bus.cmd_complete) ccCnt++;
      if (bus.cmd_inhibit_dat) datSeen++;
      bus.cmd_end = (i == 4);
      @(negedge clk);
    end
    bus.cmd_end = 1'b0;
    check("nodata_inhibit_cycles", 32'(inhCnt), 32'd5);
    check("nodata_complete_pulses", 32'(ccCnt), 32'd1);
    check("nodata_inhibit_dat", 32'(datSeen), 32'd0);

    // Read of 3 blocks into a 2-block buffer.
    issue(1'b1, 1'b1, 1'b0, 3);
    check("rd_accept_blocks", 32'(bus.blocks_left), 32'd3);
    check("rd_accept_active", 32'(bus.read_xfer_active), 32'd1);
    check("rd_accept_inhdat", 32'(bus.cmd_inhibit_dat), 32'd1);
    pulseEv(0, 0, 0, 1, 0, 0);
    check("rd_cmd_complete", 32'(bus.cmd_complete), 32'd1);
    pulseEv(1, 0, 0, 0, 0, 0);
    pulseEv(1, 0, 0, 0, 0, 0);
    check("rd_full_line_off", 32'(bus.dat_line_active), 32'd0);
    check("rd_full_blocks", 32'(bus.blocks_left), 32'd1);
    pulseEv(1, 0, 0, 0, 0, 0);
    check("rd_overflow_ignored", 32'(bus.blocks_left), 32'd1);
    issue(1'b1, 1'b1, 1'b0, 2);
    check("rd_reject_inhdat", 32'(bus.cmd_reject), 32'd1);
    check("rd_reject_nochange", 32'(bus.blocks_left), 32'd1);
    pulseEv(0, 1, 0, 0, 0, 0);
    check("rd_line_resumes", 32'(bus.dat_line_active), 32'd1);
    pulseEv(1, 0, 0, 0, 0, 0);
    check("rd_last_block", 32'(bus.blocks_left), 32'd0);
    pulseEv(0, 1, 0, 0, 0, 0);
    check("rd_not_done_yet", 32'(bus.xfer_complete), 32'd0);
    pulseEv(0, 1, 0, 0, 0, 0);
    check("rd_xfer_complete", 32'(bus.xfer_complete), 32'd1);
    check("rd_inhdat_clear", 32'(bus.cmd_inhibit_dat), 32'd0);
    @(negedge clk);
    check("rd_complete_single", 32'(bus.xfer_complete), 32'd0);
    issue(1'b1, 1'b1, 1'b0, 0);
    check("zero_blk_reject", 32'(bus.cmd_reject), 32'd1);
    check("zero_blk_nochange", 32'(bus.cmd_inhibit_cmd), 32'd0);

    // Write of 2 blocks followed by a 4-cycle busy.
    issue(1'b1, 1'b0, 1'b0, 2);
    check("wr_buf_wr_en", 32'(bus.buf_wr_en), 32'd1);
    pulseEv(0, 0, 0, 1, 0, 0);
    pulseEv(0, 0, 1, 0, 0, 0);
    check("wr_line_after_fill", 32'(bus.dat_line_active), 32'd1);
    pulseEv(0, 0, 1, 0, 0, 0);
    check("wr_all_written", 32'(bus.buf_wr_en), 32'd0);
    pulseEv(1, 0, 0, 0, 0, 0);
    bus.dat_busy = 1'b1;
    pulseEv(1, 0, 0, 0, 0, 0);
    check("wr_busy_wr_inactive", 32'(bus.write_xfer_active), 32'd0);
    check("wr_busy_line", 32'(bus.dat_line_active), 32'd1);
    repeat (3) @(negedge clk);
    bus.dat_busy = 1'b0;
    check("wr_busy_hold", 32'(bus.cmd_inhibit_dat), 32'd1);
    @(negedge clk);
    check("wr_xfer_complete", 32'(bus.xfer_complete), 32'd1);
    check("wr_inhdat_clear", 32'(bus.cmd_inhibit_dat), 32'd0);

    // Busy-only response: no completion pulse for the busy phase.
    issue(1'b0, 1'b0, 1'b1, 0);
    check("r1b_inhdat", 32'(bus.cmd_inhibit_dat), 32'd1);
    bus.dat_busy = 1'b1;
    pulseEv(0, 0, 0, 1, 0, 0);
    check("r1b_busy_line", 32'(bus.dat_line_active), 32'd1);
    @(negedge clk);
    bus.dat_busy = 1'b0;
    @(negedge clk);
    check("r1b_done", 32'(bus.cmd_inhibit_dat), 32'd0);
    check("r1b_no_xfer_complete", 32'(bus.xfer_complete), 32'd0);

    // Command error cancels a pending write; idle data events ignored.
    issue(1'b1, 1'b0, 1'b0, 2);
    pulseEv(0, 0, 0, 0, 1, 0);
    check("err_cancel_all", allOut(), 32'd0);
    pulseEv(1, 1, 1, 0, 0, 0);

    // Same-cycle block end and host read at pend=1.
    issue(1'b1, 1'b1, 1'b0, 4);
    pulseEv(0, 0, 0, 1, 0, 0);
    pulseEv(1, 0, 0, 0, 0, 0);
    pulseEv(1, 1, 0, 0, 0, 0);
    check("simul_blocks", 32'(bus.blocks_left), 32'd2);
    check("simul_rd_en", 32'(bus.buf_rd_en), 32'd1);
    pulseEv(0, 1, 0, 0, 0, 0);
    check("simul_pend_was_one", 32'(bus.buf_rd_en), 32'd0);
    pulseEv(0, 1, 0, 0, 0, 0);
    check("underflow_ignored", 32'(bus.read_xfer_active), 32'd1);

    // Abort (with a same-cycle block end) and reset in the middle of a read.
    pulseEv(0, 0, 0, 0, 0, 1);
    issue(1'b1, 1'b1, 1'b0, 5);
    check("abort_pre_blocks", 32'(bus.blocks_left), 32'd5);
    pulseEv(1, 0, 0, 0, 0, 1);
    check("abort_all_zero", allOut(), 32'd0);
    issue(1'b1, 1'b1, 1'b0, 5);
    check("after_abort_accept", 32'(bus.read_xfer_active), 32'd1);
    pulseEv(0, 0, 0, 1, 0, 0);
    rst = 1'b1;
    bus.dat_block_end = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.dat_block_end = 1'b0;
    check("rst_all_zero", allOut(), 32'd0);
    issue(1'b0, 1'b0, 1'b0, 0);
    check("after_rst_accept", 32'(bus.cmd_inhibit_cmd), 32'd1);
    pulseEv(0, 0, 0, 1, 0, 0);
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

endmodule
